mem_port_arbiter: RTL and testbench

//   Shares one single-port unified memory between instruction fetch (IF) and data access (DM: LW/SW).

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_arb_pick.sv | 33 +++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state and access-owner encodings.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter; slave = arbiter, master = pipeline + memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_if;
    logic              stall_mem;
    logic              busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_mem, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_mem, busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant decision: DM wins unless a waiting IF has been overtaken STARVE_MAX times.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             i_if_req,
    input  logic             i_dm_req,
    input  logic [CNT_W-1:0] i_starve_cnt,
    output logic             o_grant,
    output owner_t           o_owner,
    output logic [CNT_W-1:0] o_starve_nxt
);

    logic w_at_max;
    logic w_force_if;
    logic w_pick_dm;

    // NOTE: pure continuous assigns; every output is a total function of the inputs, so no latch can form.
    assign w_at_max   = (i_starve_cnt == CNT_W'(STARVE_MAX));
    assign w_force_if = i_if_req & w_at_max;
    assign w_pick_dm  = i_dm_req & ~w_force_if;

    assign o_grant = i_if_req | i_dm_req;
    assign o_owner = w_pick_dm ? OWN_DM : OWN_IF;

    // Counts DM grants that overtook a waiting IF; an IF grant or an absent IF restarts it.
    assign o_starve_nxt = (w_pick_dm & i_if_req)
                        ? (w_at_max ? i_starve_cnt : i_starve_cnt + CNT_W'(1))
                        : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, fixed-latency sequencing.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    localparam int LAT_W = cnt_width(MEM_LAT);
    localparam int STV_W = cnt_width(STARVE_MAX);

    state_t              r_state;
    owner_t              r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [STV_W-1:0]    r_starve_cnt;
    logic                r_if_ack;
    logic                r_dm_ack;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;
    logic                r_mem_en;
    logic                r_mem_we;

    logic                w_grant;
    owner_t              w_owner;
    logic [STV_W-1:0]    w_starve_nxt;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (STV_W)
    ) u_pick (
        .i_if_req     (bus.if_req),
        .i_dm_req     (bus.dm_req),
        .i_starve_cnt (r_starve_cnt),
        .o_grant      (w_grant),
        .o_owner      (w_owner),
        .o_starve_nxt (w_starve_nxt)
    );

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_IF;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
            r_if_ack     <= 1'b0;
            r_dm_ack     <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner      <= w_owner;
                        r_starve_cnt <= w_starve_nxt;
                        r_mem_en     <= 1'b1;
                        r_state      <= ST_ISSUE;
                        if (w_owner == OWN_DM) begin
                            r_we     <= bus.dm_we;
                            r_addr   <= bus.dm_addr;
                            r_wdata  <= bus.dm_wdata;
                            r_mem_we <= bus.dm_we;
                        end else begin
                            r_we     <= 1'b0;
                            r_addr   <= bus.if_addr;
                            r_wdata  <= '0;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (r_we) begin
                        r_dm_ack <= (r_owner == OWN_DM);
                        r_if_ack <= (r_owner == OWN_IF);
                        r_state  <= ST_RESP;
                    end else begin
                        r_lat_cnt <= LAT_W'(MEM_LAT);
                        r_state   <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    if (r_lat_cnt == LAT_W'(1)) begin
                        if (r_owner == OWN_DM) begin
                            r_dm_rdata <= bus.mem_rdata;
                            r_dm_ack   <= 1'b1;
                        end else begin
                            r_if_rdata <= bus.mem_rdata;
                            r_if_ack   <= 1'b1;
                        end
                        r_state <= ST_RESP;
                    end
                end

                ST_RESP: r_state <= ST_IDLE;

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.if_ack    = r_if_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_ack    = r_dm_ack;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.stall_if  = bus.if_req & ~r_if_ack;
    assign bus.stall_mem = bus.dm_req & ~r_dm_ack;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: b2 drives a MEM_LAT=2 arbiter, b1 a MEM_LAT=1 arbiter; both STARVE_MAX=4.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    // Memory behind dut2: read data appears exactly 2 cycles after mem_en, garbage otherwise.
    logic [31:0] mem2 [0:255];
    logic [31:0] rd_addr2 = '0;
    int          rd_cnt2  = 0;
    always @(posedge clk) begin
        b2.mem_rdata <= 32'hBAD0_BAD0;
        if (rd_cnt2 == 1)
            b2.mem_rdata <= (rd_addr2 == 32'h40) ? 32'h8C02_0004 : mem2[rd_addr2[9:2]];
        if (rd_cnt2 != 0) rd_cnt2 <= rd_cnt2 - 1;
        if (b2.mem_en && b2.mem_we) mem2[b2.mem_addr[9:2]] <= b2.mem_wdata;
        if (b2.mem_en && !b2.mem_we) begin
            rd_addr2 <= b2.mem_addr;
            rd_cnt2  <= 1;
        end
    end

    // Memory behind dut1: returns ~addr exactly 1 cycle after mem_en.
    always @(posedge clk) begin
        b1.mem_rdata <= 32'hBAD0_BAD0;
        if (b1.mem_en && !b1.mem_we) b1.mem_rdata <= ~b1.mem_addr;
    end

    logic use_b1;
    wire        m_mem_en   = use_b1 ? b1.mem_en    : b2.mem_en;
    wire        m_mem_we   = use_b1 ? b1.mem_we    : b2.mem_we;
    wire [31:0] m_mem_addr = use_b1 ? b1.mem_addr  : b2.mem_addr;
    wire [31:0] m_mem_wd   = use_b1 ? b1.mem_wdata : b2.mem_wdata;
    wire        m_if_ack   = use_b1 ? b1.if_ack    : b2.if_ack;
    wire        m_dm_ack   = use_b1 ? b1.dm_ack    : b2.dm_ack;
    wire [31:0] m_if_rdata = use_b1 ? b1.if_rdata  : b2.if_rdata;
    wire [31:0] m_dm_rdata = use_b1 ? b1.dm_rdata  : b2.dm_rdata;
    wire        m_stall_if = use_b1 ? b1.stall_if  : b2.stall_if;

    int total = 0;
    int bad   = 0;

    int          en_cyc, ack_cyc, en_count;
    logic        overlap, stall_hold, ack_dm, en_we;
    logic [31:0] en_addr, en_wdata, ack_rdata;

    // Observes up to 'limit' cycles (sampled on negedges) until the first ack.
    task automatic watch(input int limit);
        en_cyc = -1; ack_cyc = -1; en_count = 0;
        overlap = 1'b0; stall_hold = 1'b1; ack_dm = 1'b0; en_we = 1'b0;
        en_addr = '0; en_wdata = '0; ack_rdata = '0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (m_mem_en) begin
                en_count++;
                if (en_cyc < 0) begin
                    en_cyc = k; en_addr = m_mem_addr; en_we = m_mem_we; en_wdata = m_mem_wd;
                end
            end
            if (m_if_ack && m_dm_ack) overlap = 1'b1;
            if (m_if_ack || m_dm_ack) begin
                ack_cyc   = k;
                ack_dm    = m_dm_ack;
                ack_rdata = m_dm_ack ? m_dm_rdata : m_if_rdata;
                break;
            end
            if (!m_stall_if) stall_hold = 1'b0;
        end
    endtask

    task automatic test_reset();
        total++; if (b2.mem_en !== 1'b0 || b2.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_strobes: got en=%b we=%b want 0 0", b2.mem_en, b2.mem_we); end
        total++; if (b2.if_ack !== 1'b0 || b2.dm_ack !== 1'b0) begin bad++; $display("FAIL reset_acks: got if=%b dm=%b want 0 0", b2.if_ack, b2.dm_ack); end
        total++; if (b2.if_rdata !== 32'h0 || b2.dm_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got if=%h dm=%h want 0 0", b2.if_rdata, b2.dm_rdata); end
        total++; if (b2.mem_addr !== 32'h0 || b2.mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0 0", b2.mem_addr, b2.mem_wdata); end
        total++; if (b2.busy !== 1'b0 || b1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b %b want 0 0", b2.busy, b1.busy); end
    endtask

    task automatic test_if_read();
        use_b1 = 1'b0;
        b2.if_addr = 32'h40; b2.if_req = 1'b1;
        #1;
        total++; if (b2.stall_if !== 1'b1) begin bad++; $display("FAIL ifrd_stall_c0: got %b want 1", b2.stall_if); end
        watch(20);
        total++; if (en_cyc !== 1) begin bad++; $display("FAIL ifrd_en_cycle: got %0d want 1", en_cyc); end
        total++; if (en_addr !== 32'h40 || en_we !== 1'b0) begin bad++; $display("FAIL ifrd_mem_bus: got addr=%h we=%b want 40 0", en_addr, en_we); end
        total++; if (ack_cyc !== 4 || ack_dm !== 1'b0) begin bad++; $display("FAIL ifrd_ack: got cyc=%0d dm=%b want 4 0", ack_cyc, ack_dm); end
        total++; if (ack_rdata !== 32'h8C02_0004) begin bad++; $display("FAIL ifrd_rdata: got %h want 8c020004", ack_rdata); end
        total++; if (en_count !== 1) begin bad++; $display("FAIL ifrd_en_count: got %0d want 1", en_count); end
        total++; if (b2.stall_if !== 1'b0) begin bad++; $display("FAIL ifrd_stall_at_ack: got %b want 0", b2.stall_if); end
        b2.if_req = 1'b0;
        @(negedge clk);
        total++; if (b2.if_ack !== 1'b0 || b2.busy !== 1'b0) begin bad++; $display("FAIL ifrd_after: got ack=%b busy=%b want 0 0", b2.if_ack, b2.busy); end
    endtask

    task automatic test_dm_write();
        b2.dm_we = 1'b1; b2.dm_addr = 32'h100; b2.dm_wdata = 32'hDEAD_BEEF; b2.dm_req = 1'b1;
        #1;
        total++; if (b2.stall_mem !== 1'b1) begin bad++; $display("FAIL dmwr_stall_c0: got %b want 1", b2.stall_mem); end
        watch(20);
        total++; if (en_cyc !== 1 || en_we !== 1'b1) begin bad++; $display("FAIL dmwr_en: got cyc=%0d we=%b want 1 1", en_cyc, en_we); end
        total++; if (en_addr !== 32'h100 || en_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL dmwr_mem_bus: got %h/%h want 100/deadbeef", en_addr, en_wdata); end
        total++; if (ack_cyc !== 2 || ack_dm !== 1'b1) begin bad++; $display("FAIL dmwr_ack: got cyc=%0d dm=%b want 2 1", ack_cyc, ack_dm); end
        total++; if (b2.if_rdata !== 32'h8C02_0004) begin bad++; $display("FAIL dmwr_if_rdata_hold: got %h want 8c020004", b2.if_rdata); end
        b2.dm_req = 1'b0; b2.dm_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dm_read();
        b2.dm_we = 1'b0; b2.dm_addr = 32'h100; b2.dm_wdata = 32'h0; b2.dm_req = 1'b1;
        watch(20);
        total++; if (ack_cyc !== 4 || ack_dm !== 1'b1) begin bad++; $display("FAIL dmrd_ack: got cyc=%0d dm=%b want 4 1", ack_cyc, ack_dm); end
        total++; if (ack_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL dmrd_rdata: got %h want deadbeef", ack_rdata); end
        b2.dm_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_priority();
        b2.if_addr = 32'h40; b2.if_req = 1'b1;
        b2.dm_we = 1'b0; b2.dm_addr = 32'h100; b2.dm_req = 1'b1;
        watch(20);
        total++; if (ack_dm !== 1'b1 || ack_cyc !== 4 || en_addr !== 32'h100) begin bad++; $display("FAIL prio_dm_first: got dm=%b cyc=%0d addr=%h want 1 4 100", ack_dm, ack_cyc, en_addr); end
        total++; if (stall_hold !== 1'b1) begin bad++; $display("FAIL prio_stall_if_dm: got %b want 1", stall_hold); end
        b2.dm_req = 1'b0;
        watch(20);
        total++; if (ack_dm !== 1'b0 || en_cyc !== 2 || ack_cyc !== 5) begin bad++; $display("FAIL prio_if_next: got dm=%b en=%0d ack=%0d want 0 2 5", ack_dm, en_cyc, ack_cyc); end
        total++; if (ack_rdata !== 32'h8C02_0004 || stall_hold !== 1'b1) begin bad++; $display("FAIL prio_if_data: got %h stall=%b want 8c020004 1", ack_rdata, stall_hold); end
        b2.if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        logic exp_dm;
        b2.if_addr = 32'h40; b2.if_req = 1'b1;
        b2.dm_we = 1'b0; b2.dm_addr = 32'h100; b2.dm_req = 1'b1;
        for (int t = 0; t < 10; t++) begin
            exp_dm = (t == 4 || t == 9) ? 1'b0 : 1'b1;
            watch(20);
            total++; if (ack_dm !== exp_dm || ack_cyc !== ((t == 0) ? 4 : 5)) begin bad++; $display("FAIL starve_txn%0d: got dm=%b cyc=%0d want dm=%b", t, ack_dm, ack_cyc, exp_dm); end
        end
        b2.if_req = 1'b0; b2.dm_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        b2.if_addr = 32'h40; b2.if_req = 1'b1;
        @(negedge clk);
        total++; if (b2.mem_en !== 1'b1) begin bad++; $display("FAIL abort_issue: got mem_en=%b want 1", b2.mem_en); end
        @(negedge clk);
        rst = 1'b1; b2.if_req = 1'b0;
        #1;
        total++; if (b2.mem_en !== 1'b0 || b2.if_ack !== 1'b0 || b2.dm_ack !== 1'b0 || b2.busy !== 1'b0) begin bad++; $display("FAIL abort_immediate: got en=%b ifa=%b dma=%b busy=%b want 0", b2.mem_en, b2.if_ack, b2.dm_ack, b2.busy); end
        total++; if (b2.if_rdata !== 32'h0 || b2.mem_addr !== 32'h0) begin bad++; $display("FAIL abort_regs: got rdata=%h addr=%h want 0 0", b2.if_rdata, b2.mem_addr); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        watch(6);
        total++; if (ack_cyc !== -1 || en_count !== 0) begin bad++; $display("FAIL abort_no_ack: got ack=%0d en=%0d want -1 0", ack_cyc, en_count); end
        b2.dm_we = 1'b1; b2.dm_addr = 32'h104; b2.dm_wdata = 32'h1234_5678; b2.dm_req = 1'b1;
        watch(20);
        total++; if (en_cyc !== 1 || ack_cyc !== 2 || ack_dm !== 1'b1 || en_wdata !== 32'h1234_5678) begin bad++; $display("FAIL abort_next: got en=%0d ack=%0d dm=%b wd=%h want 1 2 1 12345678", en_cyc, ack_cyc, ack_dm, en_wdata); end
        b2.dm_req = 1'b0; b2.dm_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lat1();
        use_b1 = 1'b1;
        b1.if_addr = 32'h80; b1.if_req = 1'b1;
        watch(20);
        total++; if (en_cyc !== 1 || ack_cyc !== 3 || ack_dm !== 1'b0) begin bad++; $display("FAIL lat1_timing: got en=%0d ack=%0d dm=%b want 1 3 0", en_cyc, ack_cyc, ack_dm); end
        total++; if (ack_rdata !== 32'hFFFF_FF7F) begin bad++; $display("FAIL lat1_rdata: got %h want ffffff7f", ack_rdata); end
        b1.if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int   m_cnt = 0;
        int   exp_lat;
        logic exp_dm, pend_if, pend_dm, we;
        logic [1:0] sel;
        use_b1 = 1'b1;
        for (int it = 0; it < 100; it++) begin
            sel = 2'($urandom_range(1, 3));
            pend_if = sel[0]; pend_dm = sel[1];
            we = 1'($urandom_range(0, 1));
            b1.if_addr = $urandom & 32'hFFFF_FFFC;
            b1.dm_addr = $urandom & 32'hFFFF_FFFC;
            b1.dm_wdata = $urandom;
            b1.dm_we = we;
            b1.if_req = pend_if; b1.dm_req = pend_dm;
            for (int n = 0; n < 2 && (pend_if || pend_dm); n++) begin
                exp_dm = pend_dm && !(pend_if && m_cnt == 4);
                if (exp_dm) m_cnt = pend_if ? ((m_cnt == 4) ? 4 : m_cnt + 1) : 0;
                else        m_cnt = 0;
                exp_lat = ((exp_dm && we) ? 2 : 3) + n;
                watch(20);
                total++; if (ack_dm !== exp_dm || ack_cyc !== exp_lat) begin bad++; $display("FAIL rnd%0d_grant: got dm=%b cyc=%0d want dm=%b cyc=%0d", it, ack_dm, ack_cyc, exp_dm, exp_lat); end
                total++; if (en_count !== 1 || overlap !== 1'b0) begin bad++; $display("FAIL rnd%0d_strobe: got en_count=%0d overlap=%b want 1 0", it, en_count, overlap); end
                if (!(exp_dm && we)) begin
                    total++; if (ack_rdata !== (exp_dm ? ~b1.dm_addr : ~b1.if_addr)) begin bad++; $display("FAIL rnd%0d_rdata: got %h", it, ack_rdata); end
                end
                if (ack_cyc < 0) begin
                    pend_if = 1'b0; pend_dm = 1'b0;
                end else if (ack_dm) begin
                    pend_dm = 1'b0;
                end else begin
                    pend_if = 1'b0;
                end
                b1.if_req = pend_if; b1.dm_req = pend_dm;
            end
            b1.if_req = 1'b0; b1.dm_req = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; use_b1 = 1'b0;
        b2.if_req = 1'b0; b2.if_addr = '0; b2.dm_req = 1'b0; b2.dm_we = 1'b0; b2.dm_addr = '0; b2.dm_wdata = '0;
        b1.if_req = 1'b0; b1.if_addr = '0; b1.dm_req = 1'b0; b1.dm_we = 1'b0; b1.dm_addr = '0; b1.dm_wdata = '0;
        #1;
        test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_if_read();
        test_dm_write();
        test_dm_read();
        test_priority();
        test_starvation();
        test_reset_abort();
        test_lat1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
